// File: rtl/rs422_uart_rx.sv
// RS-422 serial receive stage: synchronizes rxd, recovers 8N1 frames (LSB first) by
// sampling at bit centres, and presents each good byte with a one-cycle strobe.
module rs422_uart_rx #(
  parameter int CLKS_PER_BIT = 512,  // must be >= 8
  parameter int DATA_BITS    = 8     // must be >= 2
) (
  input  logic                 clk59m,
  input  logic                 rst,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 rx_busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [CNT_W-1:0] HALF_END = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_END = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_t;

  state_t               state_q, state_d;
  logic                 rxd_m, rxd_s;
  logic [CNT_W-1:0]     clk_cnt_q, clk_cnt_d;
  logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 load_byte;
  logic                 err_pulse;

  // NOTE: every signal written here gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q + 1'b1;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    load_byte = 1'b0;
    err_pulse = 1'b0;

    unique case (state_q)
      IDLE: begin
        clk_cnt_d = '0;
        if (!rxd_s) state_d = START;
      end
      START: begin
        // Line back high at mid start bit means it was a glitch, not a frame.
        if (clk_cnt_q == HALF_END) begin
          clk_cnt_d = '0;
          bit_cnt_d = '0;
          state_d   = rxd_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (clk_cnt_q == FULL_END) begin
          clk_cnt_d = '0;
          shift_d   = {rxd_s, shift_q[DATA_BITS-1:1]};
          if (bit_cnt_q == LAST_BIT) state_d = STOP;
          else bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      STOP: begin
        // Leaving at stop-bit centre leaves half a bit to catch a back-to-back start.
        if (clk_cnt_q == FULL_END) begin
          clk_cnt_d = '0;
          if (rxd_s) begin
            load_byte = 1'b1;
            state_d   = IDLE;
          end else begin
            err_pulse = 1'b1;
            state_d   = BREAK;
          end
        end
      end
      BREAK: begin
        clk_cnt_d = '0;
        if (rxd_s) state_d = IDLE;
      end
      default: begin
        clk_cnt_d = '0;
        state_d   = IDLE;
      end
    endcase
  end

  assign rx_busy = (state_q != IDLE);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk59m) begin
    if (!rst) begin
      state_q   <= IDLE;
      rxd_m     <= 1'b1;
      rxd_s     <= 1'b1;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state_q   <= state_d;
      rxd_m     <= rxd;
      rxd_s     <= rxd_m;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      rx_valid  <= load_byte;
      frame_err <= err_pulse;
      if (load_byte) rx_data <= shift_q;
    end
  end

endmodule
